// File: rtl/gp_dma_chan_arb_if.sv
// Channel-bank / engine handshake bundle for gp_dma_chan_arb.
// master = arbiter side, slave = channel banks plus engine.
interface gp_dma_chan_arb_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  logic                  arb_enable;
  logic [NUM_CH-1:0]     ch_pending;
  logic [3*NUM_CH-1:0]   ch_pri;
  logic                  eng_done;
  logic                  eng_start;
  logic                  eng_abort;
  logic                  grant_valid;
  logic [CH_W-1:0]       grant_id;
  logic [NUM_CH-1:0]     grant_vec;
  logic [NUM_CH-1:0]     ch_done;

  modport master (
    input  arb_enable,
    input  ch_pending,
    input  ch_pri,
    input  eng_done,
    output eng_start,
    output eng_abort,
    output grant_valid,
    output grant_id,
    output grant_vec,
    output ch_done
  );

  modport slave (
    output arb_enable,
    output ch_pending,
    output ch_pri,
    output eng_done,
    input  eng_start,
    input  eng_abort,
    input  grant_valid,
    input  grant_id,
    input  grant_vec,
    input  ch_done
  );
endinterface

// File: rtl/gp_dma_chan_arb.sv
// Shares one gp_dma engine between NUM_CH register banks.
// Priority arbitration with round-robin tie-break; all outputs registered.
module gp_dma_chan_arb #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              cbus_clk,
  input  logic              cbus_rst_n,
  gp_dma_chan_arb_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_BUSY,
    S_ABORT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_d;

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_ptr_d;
  logic [CH_W-1:0]   gid_q;
  logic [CH_W-1:0]   gid_d;
  logic              gv_q;
  logic              gv_d;
  logic              start_q;
  logic              start_d;
  logic              abort_q;
  logic              abort_d;
  logic [NUM_CH-1:0] gvec_q;
  logic [NUM_CH-1:0] gvec_d;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] done_d;

  logic              win_found;
  logic [CH_W-1:0]   win_id;
  logic [2:0]        win_pri;
  logic [CH_W:0]     scan_sum;
  logic [CH_W-1:0]   scan_idx;

  // Scan starts just after rr_ptr; strict < keeps the first
  // equal-priority channel in scan order.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_pri   = 3'd7;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      scan_sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (scan_sum >= (CH_W+1)'(NUM_CH))
        scan_sum = scan_sum - (CH_W+1)'(NUM_CH);
      scan_idx = scan_sum[CH_W-1:0];
      if (bus.ch_pending[scan_idx] &&
          (!win_found ||
           bus.ch_pri[3*scan_idx +: 3] < win_pri)) begin
        win_found = 1'b1;
        win_id    = scan_idx;
        win_pri   = bus.ch_pri[3*scan_idx +: 3];
      end
    end
  end

  always_ff @(posedge cbus_clk or negedge cbus_rst_n) begin
    if (!cbus_rst_n) begin
      state   <= S_IDLE;
      rr_ptr  <= CH_W'(NUM_CH-1);
      gid_q   <= '0;
      gv_q    <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      gvec_q  <= '0;
      done_q  <= '0;
    end else begin
      state   <= state_d;
      rr_ptr  <= rr_ptr_d;
      gid_q   <= gid_d;
      gv_q    <= gv_d;
      start_q <= start_d;
      abort_q <= abort_d;
      gvec_q  <= gvec_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (bus.arb_enable && (|bus.ch_pending))
          state_d = S_ARB;
      end
      S_ARB: begin
        state_d = win_found ? S_START : S_IDLE;
      end
      S_START: begin
        state_d = S_BUSY;
      end
      S_BUSY: begin
        // Completion beats a simultaneous pending drop.
        if (bus.eng_done)
          state_d = S_DONE;
        else if (!bus.ch_pending[gid_q])
          state_d = S_ABORT;
      end
      S_ABORT: begin
        if (bus.eng_done)
          state_d = S_IDLE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register inputs are derived from the next state so that
  // every output lines up with the state it belongs to.
  always_comb begin
    gid_d    = gid_q;
    rr_ptr_d = rr_ptr;
    if (state == S_ARB && win_found) begin
      gid_d    = win_id;
      rr_ptr_d = win_id;
    end
    start_d = (state_d == S_START);
    abort_d = (state_d == S_ABORT) && (state != S_ABORT);
    gv_d    = (state_d == S_START) || (state_d == S_BUSY) ||
              (state_d == S_ABORT) || (state_d == S_DONE);
    gvec_d  = '0;
    gvec_d[gid_d] = gv_d;
    done_d  = '0;
    done_d[gid_d] = (state_d == S_DONE);
  end

  assign bus.eng_start   = start_q;
  assign bus.eng_abort   = abort_q;
  assign bus.grant_valid = gv_q;
  assign bus.grant_id    = gid_q;
  assign bus.grant_vec   = gvec_q;
  assign bus.ch_done     = done_q;

endmodule
